muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage. It sits beside the single-cycle ALU and takes over the MUL/MULH/DIV/MOD operations that the ALU does not implement.
- One operation is in flight at a time, with a valid/ready handshake on both sides.
- Supports flush from the pipeline and a tag that travels with the operation.

Parameters:
- WIDTH, 32, operand/result width in bits (must be even, >= 8).
- MUL_LAT, 2, cycles from accept to result valid for multiply ops (1..4).
- TAG_W, 4, width of the opaque tag carried with each operation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  abort any in-flight op; drops any op offered this cycle.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  3  mdu_op_t: MUL, MULH, MULHU, DIV, DIVU, MOD, MODU.
- opd1_i  in  WIDTH  rj operand.
- opd2_i  in  WIDTH  rk operand.
- tag_i  in  TAG_W  opaque id.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- res_o  out  WIDTH  result.
- tag_o  out  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready_o=1, valid_o=0, res_o=0, tag_o=0, iteration counter=0.
- Accept: a request is taken when valid_i & ready_o & ~flush_i. ready_o=1 only in IDLE. Operands, op and tag are registered on acceptance.
- FSM states and transitions:
  - IDLE -> MUL (mul ops) or DIV (div/mod ops).
  - MUL -> DONE after MUL_LAT-1 further cycles. Result valid exactly MUL_LAT cycles after the accept edge.
  - DIV, divisor nonzero: one prep cycle (absolute values for signed ops), then WIDTH restoring radix-2 iterations (1 quotient bit/cycle, counter WIDTH-1 down to 0), then one sign-fix cycle, then DONE. Latency is WIDTH+2 cycles after accept (34 for WIDTH=32).
  - DIV, divisor zero: detected at prep, goes straight to DONE. Latency is 2 cycles.
  - DONE: valid_o=1; res_o/tag_o held stable until ready_i=1. On the ready_i cycle -> IDLE. ready_o stays 0 during that cycle (no same-cycle re-accept).
- Arithmetic:
  - MUL = low WIDTH bits of the product.
  - MULH = high WIDTH bits of the signed x signed product.
  - MULHU = high WIDTH bits of the unsigned x unsigned product.
  - DIV/MOD truncate toward zero; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (min / -1): quotient = min, remainder = 0, no exception.
- Flush:
  - flush_i=1 in any state: next state IDLE, valid_o=0, counter cleared. The in-flight result is discarded.
  - flush_i=1 in IDLE with valid_i=1: the request is not accepted.
  - flush in DONE with ready_i=1 the same cycle: the result counts as consumed. The consumer must ignore it.
- Reset mid-operation: immediate return to the reset values; no result is produced.
- ready_i is ignored outside DONE. op_i/opd*_i are don't-care when valid_i=0.
- Illegal op encodings return 0 via the DONE path after 1 cycle.

Decomposition:
- Shared package (decoder package): mdu_op_t enum and its encodings, plus the constants MDU_OP_MUL..MDU_OP_MODU.
- Sub-module muldiv_div_iter: restoring divider datapath (partial remainder register, quotient shift register, count). It receives start/abs operands from the parent FSM and returns done, quotient and remainder. Sign handling stays in the parent.
- The multiplier is an inline registered product pipeline of depth MUL_LAT.

Test Plan:
- MUL 0xFFFFFFFF x 0x00000002, MULH and MULHU with the same operands:
  - res 0xFFFFFFFE, 0xFFFFFFFF, 0x00000001 respectively.
  - valid_o exactly 2 cycles after accept.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; MOD -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - Latency 34 cycles each.
- Divide by zero, DIVU 5/0 and MODU 5/0:
  - results 0xFFFFFFFF and 0x00000005.
  - valid_o 2 cycles after accept.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; MOD -> 0.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> res_o/tag_o stable and ready_o=0 throughout. Release -> IDLE; a new op is accepted the cycle after.
- Flush and reset:
  - flush_i at iteration 10 of a DIV -> valid_o never asserts, ready_o=1 next cycle, and a following MUL 3x4 returns 12 with its own tag.
  - rst_n pulse mid-MUL -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared decode definitions for the multiply/divide unit: operation encodings,
// FSM state encoding and small op-class helpers.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MDU_OP_MUL   = 3'd0,
        MDU_OP_MULH  = 3'd1,
        MDU_OP_MULHU = 3'd2,
        MDU_OP_DIV   = 3'd3,
        MDU_OP_DIVU  = 3'd4,
        MDU_OP_MOD   = 3'd5,
        MDU_OP_MODU  = 3'd6
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_PREP = 3'd2,
        ST_RUN  = 3'd3,
        ST_FIX  = 3'd4,
        ST_DONE = 3'd5
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return op inside {MDU_OP_MUL, MDU_OP_MULH, MDU_OP_MULHU};
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return op inside {MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_MOD, MDU_OP_MODU};
    endfunction

    function automatic logic is_signed_div(input logic [2:0] op);
        return op inside {MDU_OP_DIV, MDU_OP_MOD};
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per cycle.
// Sign handling and divide-by-zero are resolved by the parent.
module muldiv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             last_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   shifted, trial;

    // Quotient register doubles as the dividend shifter; its MSB feeds the remainder.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign last_o  = run_q & (cnt_q == '0);
    assign quo_o   = quo_q;
    assign rem_o   = rem_q;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(WIDTH - 1);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (run_q) begin
            rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MUL/MULH/MULHU/DIV/DIVU/MOD/MODU unit for the EX stage.
// One operation in flight, valid/ready on both sides, flushable, tag carried through.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opd1_i,
    input  logic [WIDTH-1:0] opd2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic [TAG_W-1:0] tag_o
);
    mdu_state_t       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TAG_W-1:0] tag_q;

    logic [WIDTH-1:0] a_q, b_q, prod_q;
    logic [2:0]       op_q;
    logic             qneg_q, rneg_q, dz_q;

    logic             accept, div_start, div_last;
    logic             neg_a, neg_b, mul_sgn;
    logic [WIDTH-1:0] abs_a, abs_b, quo, rem, mul_res, fix_res;
    logic [2*WIDTH-1:0] mul_a, mul_b, mul_prod;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    assign ready_o = (state_q == ST_IDLE);
    assign valid_o = (state_q == ST_DONE);
    assign res_o   = res_q;
    assign tag_o   = tag_q;
    assign accept  = valid_i & ready_o & ~flush_i;

    // Only MULH sign-extends; the low half is identical for every multiply flavour.
    assign mul_sgn  = (op_q == MDU_OP_MULH);
    assign mul_a    = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
    assign mul_b    = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
    assign mul_prod = mul_a * mul_b;
    assign mul_res  = (op_q == MDU_OP_MUL) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];

    assign neg_a = is_signed_div(op_q) & a_q[WIDTH-1];
    assign neg_b = is_signed_div(op_q) & b_q[WIDTH-1];
    assign abs_a = cond_neg(neg_a, a_q);
    assign abs_b = cond_neg(neg_b, b_q);

    muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .start_i    (div_start),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .last_o     (div_last),
        .quo_o      (quo),
        .rem_o      (rem)
    );

    // min / -1 falls out naturally: |min| / 1 = min with a positive quotient sign.
    always_comb begin
        fix_res = '0;
        case (op_q)
            MDU_OP_DIV, MDU_OP_DIVU: fix_res = dz_q ? '1  : cond_neg(qneg_q, quo);
            MDU_OP_MOD, MDU_OP_MODU: fix_res = dz_q ? a_q : cond_neg(rneg_q, rem);
            default:                 fix_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul_op(op_i)) begin
                        state_d = ST_MUL;
                        cnt_d   = 2'(MUL_LAT - 1);
                    end else if (is_div_op(op_i)) begin
                        state_d = ST_PREP;
                    end else begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                    res_d   = (MUL_LAT == 1) ? mul_res : prod_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_PREP: begin
                if (b_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    state_d   = ST_RUN;
                    div_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (div_last) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_DONE;
                res_d   = fix_res;
            end
            ST_DONE: begin
                if (ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            res_d     = res_q;
            div_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            if (accept) tag_q <= tag_i;
        end
    end

    // Datapath registers carry no reset; they are only read after being loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= opd1_i;
            b_q  <= opd2_i;
            op_q <= op_i;
        end
        prod_q <= mul_res;
        if (state_q == ST_PREP) begin
            qneg_q <= neg_a ^ neg_b;
            rneg_q <= neg_a;
            dz_q   <= (b_q == '0);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus randomized ops with random
// backpressure and flushes, scored against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk, rst_n, flush_i, valid_i, ready_o, valid_o, ready_i;
    logic [2:0]    op_i;
    logic [W-1:0]  opd1_i, opd2_i, res_o;
    logic [3:0]    tag_i, tag_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bp_mode = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   tag;
        int           acc;
        int           lat;
        bit           seen;
    } exp_t;
    exp_t q[$];

    muldiv_unit #(.WIDTH(W), .MUL_LAT(2), .TAG_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .opd1_i  (opd1_i),
        .opd2_i  (opd2_i),
        .tag_i   (tag_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .res_o   (res_o),
        .tag_o   (tag_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        up;
        logic signed [63:0] sp;
        int                 sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        up  = {32'd0, a} * {32'd0, b};
        sp  = longint'(sa) * longint'(sb);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return up[31:0];
            3'd1: return sp[63:32];
            3'd2: return up[63:32];
            3'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                else if (ovf) return 32'h8000_0000;
                else return 32'(sa / sb);
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            3'd5: begin
                if (b == 0) return a;
                else if (ovf) return 32'd0;
                else return 32'(sa % sb);
            end
            3'd6: begin
                if (b == 0) return a;
                else return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        if (op <= 3'd2) return 2;
        else if (op == 3'd7) return 1;
        else if (b == 0) return 2;
        else return W + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0: ready_i = 1'b1;
                1: ready_i = 1'b0;
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: expectations are queued at acceptance and checked every cycle valid_o is high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
            end else begin
                if (valid_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", {31'd0, valid_o}, 32'd0);
                    end else begin
                        if (!q[0].seen) begin
                            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                            q[0].seen = 1'b1;
                        end
                        chk("res", res_o, q[0].res);
                        chk("tag", {28'd0, tag_o}, {28'd0, q[0].tag});
                        chk("ready_in_done", {31'd0, ready_o}, 32'd0);
                    end
                end else if (q.size() > 0 && (cyc - q[0].acc) > 100) begin
                    chk("result_timeout", {31'd0, valid_o}, 32'd1);
                    void'(q.pop_front());
                end
                if (flush_i) begin
                    q.delete();
                end else begin
                    if (valid_o && ready_i && q.size() > 0) void'(q.pop_front());
                    if (valid_i && ready_o) begin
                        e.res  = model(op_i, opd1_i, opd2_i);
                        e.tag  = tag_i;
                        e.acc  = cyc + 1;
                        e.lat  = exp_lat(op_i, opd2_i);
                        e.seen = 1'b0;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic wait_idle();
        int n = 0;
        while (!ready_o && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_o) chk("idle_timeout", {31'd0, ready_o}, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!valid_o) chk("valid_timeout", {31'd0, valid_o}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        wait_idle();
        valid_i = 1'b1;
        op_i    = op;
        opd1_i  = a;
        opd2_i  = b;
        tag_i   = tag;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        opd1_i  = $urandom;
        opd2_i  = $urandom;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] exp, input string name);
        issue(op, a, b, tag);
        wait_valid();
        chk(name, res_o, exp);
        chk({name, "_tag"}, {28'd0, tag_o}, {28'd0, tag});
        wait_idle();
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          k;
        clk = 1'b0; rst_n = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
        op_i = '0; opd1_i = '0; opd2_i = '0; tag_i = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_res", res_o, 32'd0);
        chk("rst_tag", {28'd0, tag_o}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 4'h1, 32'hFFFF_FFFE, "mul");
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 4'h2, 32'hFFFF_FFFF, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 4'h3, 32'h0000_0001, "mulhu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 4'h4, 32'hFFFF_FFFD, "div_neg");
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 4'h5, 32'hFFFF_FFFF, "mod_neg");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 4'h6, 32'h7FFF_FFFC, "divu");
        run_op(3'd4, 32'd5, 32'd0, 4'h7, 32'hFFFF_FFFF, "divu_zero");
        run_op(3'd6, 32'd5, 32'd0, 4'h8, 32'h0000_0005, "modu_zero");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'h9, 32'h8000_0000, "div_ovf");
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 4'hA, 32'h0000_0000, "mod_ovf");
        run_op(3'd7, 32'd5, 32'd6, 4'hB, 32'h0000_0000, "illegal");

        bp_mode = 1;
        @(posedge clk);
        #1;
        issue(3'd0, 32'h0000_1234, 32'h0000_0010, 4'h5);
        wait_valid();
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, valid_o}, 32'd1);
            chk("bp_ready_o", {31'd0, ready_o}, 32'd0);
            chk("bp_res", res_o, 32'h0001_2340);
            chk("bp_tag", {28'd0, tag_o}, 32'd5);
        end
        bp_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_release_ready", {31'd0, ready_o}, 32'd1);
        issue(3'd2, 32'h0001_0000, 32'h0001_0000, 4'h6);
        chk("bp_next_accepted", {31'd0, ready_o}, 32'd0);
        wait_valid();
        chk("bp_next_res", res_o, 32'd1);
        wait_idle();

        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; opd1_i = 32'd7; opd2_i = 32'd7; tag_i = 4'h2;
        @(posedge clk);
        #1;
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_ready", {31'd0, ready_o}, 32'd1);
        chk("flush_idle_valid", {31'd0, valid_o}, 32'd0);
        repeat (5) @(posedge clk);
        #1;

        issue(3'd3, 32'd1000, 32'd7, 4'hC);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_div_ready", {31'd0, ready_o}, 32'd1);
        chk("flush_div_valid", {31'd0, valid_o}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        run_op(3'd0, 32'd3, 32'd4, 4'h9, 32'd12, "mul_after_flush");

        issue(3'd0, 32'd5, 32'd6, 4'h3);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready_o}, 32'd1);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_res", res_o, 32'd0);
        chk("midrst_tag", {28'd0, tag_o}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'd3, 32'd100, 32'd7, 4'h4, 32'd14, "div_after_rst");

        bp_mode = 2;
        for (int i = 0; i < 250; i++) begin
            rop = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            ra  = pick();
            rb  = pick();
            issue(rop, ra, rb, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(0, 40);
                repeat (k) begin
                    @(posedge clk);
                    #1;
                end
                flush_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
            end
            wait_idle();
        end
        bp_mode = 0;
        repeat (5) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
